// File: rtl/cheri_tsmap_mem.sv
// Temporal-safety revocation bitmap store: 1-cycle core lookup port, OBI-style bus slave
// for software fill, and a hardware sweep that zeroes the map on command.
module cheri_tsmap_mem #(
  parameter logic [31:0] TSMapBase = 32'h2002_f000,
  parameter int unsigned TSMapSize = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tsmap_cs_i,
  input  logic [15:0] tsmap_addr_i,
  output logic [31:0] tsmap_rdata_o,
  input  logic        bus_req_i,
  output logic        bus_gnt_o,
  input  logic        bus_we_i,
  input  logic [3:0]  bus_be_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_rvalid_o,
  output logic [31:0] bus_rdata_o,
  output logic        bus_err_o,
  input  logic        clr_start_i,
  output logic        clr_busy_o
);

  localparam int AW = $clog2(TSMapSize);
  localparam int PW = AW + 1;
  localparam logic [32:0] SPAN = 33'(64'(TSMapSize) * 64'd4);
  localparam logic [PW-1:0] LAST = PW'(TSMapSize - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [31:0]   mem [TSMapSize];

  logic [32:0]   offset;
  logic          in_range;
  logic [AW-1:0] bus_idx;
  logic          core_hit;
  logic          bus_wr;
  logic          sweep_wr;

  // A 33-bit difference makes addresses below the base come out negative.
  assign offset   = {1'b0, bus_addr_i} - {1'b0, TSMapBase};
  assign in_range = ~offset[32] && (offset < SPAN);
  assign bus_idx  = offset[AW+1:2];
  assign core_hit = ({1'b0, tsmap_addr_i} < 17'(TSMapSize));

  assign bus_gnt_o = bus_req_i & ~tsmap_cs_i & (state == IDLE);
  assign bus_wr    = bus_gnt_o & bus_we_i & in_range;
  // The sweep yields to core lookups and stops writing the moment reset is seen.
  assign sweep_wr  = (state == CLEAR) & ~tsmap_cs_i & ~rst_i;

  // Storage: sweep and bus writes are mutually exclusive through the grant rule.
  always_ff @(posedge clk_i) begin
    if (sweep_wr) begin
      mem[ptr[AW-1:0]] <= '0;
    end else if (bus_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus_be_i[b]) begin
          mem[bus_idx][8*b +: 8] <= bus_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Core lookup: registered, holds while cs is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tsmap_rdata_o <= '0;
    end else if (tsmap_cs_i) begin
      tsmap_rdata_o <= core_hit ? mem[tsmap_addr_i[AW-1:0]] : '0;
    end
  end

  // Bus response: one pulse per grant, data only for in-range reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus_rvalid_o <= 1'b0;
      bus_err_o    <= 1'b0;
      bus_rdata_o  <= '0;
    end else begin
      bus_rvalid_o <= bus_gnt_o;
      bus_err_o    <= bus_gnt_o & ~in_range;
      bus_rdata_o  <= (bus_gnt_o & ~bus_we_i & in_range) ? mem[bus_idx] : '0;
    end
  end

  // Clear sweep FSM; the extra pointer bit keeps terminal count free of wrap aliasing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      ptr        <= '0;
      clr_busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_start_i) begin
            state      <= CLEAR;
            ptr        <= '0;
            clr_busy_o <= 1'b1;
          end
        end
        CLEAR: begin
          if (!tsmap_cs_i) begin
            ptr <= ptr + 1'b1;
            if (ptr == LAST) begin
              state      <= IDLE;
              clr_busy_o <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          clr_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cheri_tsmap_mem.sv
// Scoreboard bench for cheri_tsmap_mem: the driver queues expected responses, a negedge
// monitor pops and compares whenever the DUT presents core or bus data.
module tb_cheri_tsmap_mem;

  localparam logic [31:0] BASE = 32'h2002_f000;
  localparam int NSWEEP = 1124;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        tsmap_cs_i;
  logic [15:0] tsmap_addr_i;
  logic [31:0] tsmap_rdata_o;
  logic        bus_req_i;
  logic        bus_gnt_o;
  logic        bus_we_i;
  logic [3:0]  bus_be_i;
  logic [31:0] bus_addr_i;
  logic [31:0] bus_wdata_i;
  logic        bus_rvalid_o;
  logic [31:0] bus_rdata_o;
  logic        bus_err_o;
  logic        clr_start_i;
  logic        clr_busy_o;

  always #5 clk = ~clk;

  cheri_tsmap_mem #(.TSMapBase(BASE), .TSMapSize(1024)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .tsmap_cs_i(tsmap_cs_i), .tsmap_addr_i(tsmap_addr_i), .tsmap_rdata_o(tsmap_rdata_o),
    .bus_req_i(bus_req_i), .bus_gnt_o(bus_gnt_o), .bus_we_i(bus_we_i), .bus_be_i(bus_be_i),
    .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i), .bus_rvalid_o(bus_rvalid_o),
    .bus_rdata_o(bus_rdata_o), .bus_err_o(bus_err_o),
    .clr_start_i(clr_start_i), .clr_busy_o(clr_busy_o)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] core_q[$];
  logic [32:0] bus_q[$];
  logic        cs_d = 1'b0;
  int          busy_cycles = 0;
  int          busy_base = 0;
  int          exp_busy = 0;
  logic        chk_gnt = 1'b0;
  logic        exp_gnt = 1'b0;
  logic        chk_rst = 1'b0;
  logic        chk_cnt = 1'b0;
  logic        chk_done = 1'b0;
  logic [31:0] ce;
  logic [32:0] be;
  logic        pat [NSWEEP];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=response expected=none t=%0t", name, $time);
  endtask

  always @(posedge clk) cs_d <= tsmap_cs_i;

  // Monitor: the only process that touches the counters.
  always @(negedge clk) begin
    if (clr_busy_o) busy_cycles++;
    if (chk_gnt) chk("gnt", 64'(bus_gnt_o), 64'(exp_gnt));
    if (cs_d) begin
      if (core_q.size() == 0) miss("core_unexpected");
      else begin
        ce = core_q.pop_front();
        chk("core_rdata", 64'(tsmap_rdata_o), 64'(ce));
      end
    end
    if (bus_rvalid_o) begin
      if (bus_q.size() == 0) miss("bus_unexpected");
      else begin
        be = bus_q.pop_front();
        chk("bus_err", 64'(bus_err_o), 64'(be[32]));
        chk("bus_rdata", 64'(bus_rdata_o), 64'(be[31:0]));
      end
    end
    if (chk_rst) begin
      chk("rst_busy", 64'(clr_busy_o), 64'd0);
      chk("rst_rvalid", 64'(bus_rvalid_o), 64'd0);
      chk("rst_err", 64'(bus_err_o), 64'd0);
      chk("rst_bus_rdata", 64'(bus_rdata_o), 64'd0);
      chk("rst_core_rdata", 64'(tsmap_rdata_o), 64'd0);
    end
    if (chk_cnt) chk("busy_cycles", 64'(busy_cycles - busy_base), 64'(exp_busy));
    if (chk_done) chk("leftover", 64'(core_q.size() + bus_q.size()), 64'd0);
  end

  task automatic cyc(input logic cs, input logic [15:0] ca, input logic [31:0] cexp,
                     input logic req, input logic we, input logic [3:0] ben,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic gexp, input logic eexp, input logic [31:0] bexp);
    @(posedge clk); #1;
    tsmap_cs_i = cs; tsmap_addr_i = ca; bus_req_i = req; bus_we_i = we;
    bus_be_i = ben; bus_addr_i = a; bus_wdata_i = wd; clr_start_i = 1'b0;
    exp_gnt = gexp; chk_gnt = 1'b1;
    if (cs) core_q.push_back(cexp);
    if (gexp) bus_q.push_back({eexp, bexp});
  endtask

  task automatic idle();
    cyc(1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic bwr(input logic [31:0] a, input logic [3:0] ben, input logic [31:0] wd,
                     input logic err);
    cyc(1'b0, 16'd0, 32'd0, 1'b1, 1'b1, ben, a, wd, 1'b1, err, 32'd0);
  endtask

  task automatic brd(input logic [31:0] a, input logic err, input logic [31:0] exp);
    cyc(1'b0, 16'd0, 32'd0, 1'b1, 1'b0, 4'h0, a, 32'd0, 1'b1, err, exp);
  endtask

  task automatic look(input logic [15:0] ca, input logic [31:0] exp);
    cyc(1'b1, ca, exp, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic start_clear();
    @(posedge clk); #1;
    tsmap_cs_i = 1'b0; bus_req_i = 1'b0; bus_we_i = 1'b0; clr_start_i = 1'b1;
    exp_gnt = 1'b0; chk_gnt = 1'b1;
  endtask

  task automatic pulse_rst_check();
    chk_rst = 1'b1;
    @(negedge clk); #1;
    chk_rst = 1'b0;
  endtask

  task automatic fill_ones();
    for (int i = 0; i < 1024; i++) bwr(BASE + 32'(4 * i), 4'hF, 32'hFFFF_FFFF, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; tsmap_cs_i = 1'b0; tsmap_addr_i = '0; bus_req_i = 1'b0; bus_we_i = 1'b0;
    bus_be_i = '0; bus_addr_i = '0; bus_wdata_i = '0; clr_start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    pulse_rst_check();

    // Write then immediate core lookup of the same word
    bwr(BASE + 32'h10, 4'hF, 32'hA5A5_0001, 1'b0);
    look(16'd4, 32'hA5A5_0001);

    // Partial byte write
    bwr(BASE + 32'h20, 4'hF, 32'h1111_1111, 1'b0);
    bwr(BASE + 32'h20, 4'b0100, 32'h00FF_0000, 1'b0);
    brd(BASE + 32'h20, 1'b0, 32'h11FF_1111);

    // Core priority over a pending bus request
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 16'd4, 32'hA5A5_0001, 1'b1, 1'b0, 4'h0, BASE + 32'h10, 32'd0,
          1'b0, 1'b0, 32'd0);
    brd(BASE + 32'h10, 1'b0, 32'hA5A5_0001);

    // Range boundaries, including aliasing guards above and below the map
    bwr(BASE, 4'hF, 32'hCAFE_0000, 1'b0);
    bwr(BASE + 32'hFFC, 4'hF, 32'h1234_5678, 1'b0);
    brd(BASE + 32'h1000, 1'b1, 32'd0);
    bwr(BASE + 32'h1000, 4'hF, 32'hDEAD_BEEF, 1'b1);
    bwr(BASE - 32'd4, 4'hF, 32'hDEAD_BEEF, 1'b1);
    brd(BASE, 1'b0, 32'hCAFE_0000);
    brd(BASE + 32'hFFC, 1'b0, 32'h1234_5678);
    look(16'd1024, 32'd0);
    look(16'hFFFF, 32'd0);
    look(16'd0, 32'hCAFE_0000);
    look(16'd1023, 32'h1234_5678);

    // Full sweep with 100 core lookups interleaved and the bus requesting throughout
    fill_ones();
    idle();
    for (int k = 0; k < NSWEEP; k++) pat[k] = 1'b0;
    for (int n = 0; n < 100; ) begin
      int r;
      r = int'($urandom_range(0, NSWEEP - 2));
      if (!pat[r]) begin
        pat[r] = 1'b1;
        n++;
      end
    end
    busy_base = busy_cycles;
    start_clear();
    for (int k = 0; k < NSWEEP; k++)
      cyc(pat[k], 16'd1023, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'h0, BASE, 32'd0,
          1'b0, 1'b0, 32'd0);
    repeat (3) idle();
    exp_busy = NSWEEP;
    chk_cnt = 1'b1;
    @(negedge clk); #1;
    chk_cnt = 1'b0;
    for (int i = 0; i < 1024; i++) brd(BASE + 32'(4 * i), 1'b0, 32'd0);

    // Reset ten cycles into a sweep
    fill_ones();
    idle();
    start_clear();
    repeat (10) idle();
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    pulse_rst_check();
    for (int i = 0; i < 10; i++) brd(BASE + 32'(4 * i), 1'b0, 32'd0);
    for (int i = 11; i < 1024; i++) brd(BASE + 32'(4 * i), 1'b0, 32'hFFFF_FFFF);

    // A grant coinciding with reset produces no response
    @(posedge clk); #1;
    rst_i = 1'b1; bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = BASE; tsmap_cs_i = 1'b0;
    exp_gnt = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; bus_req_i = 1'b0; exp_gnt = 1'b0;
    pulse_rst_check();
    brd(BASE, 1'b0, 32'd0);

    repeat (3) idle();
    chk_done = 1'b1;
    @(negedge clk); #1;
    chk_done = 1'b0;
    chk_gnt = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
